// File: rtl/mant_mult_seq_if.sv
// Handshake and data bundle between the FP multiply control and the significand multiplier.
// The master issues start with its operands; the slave returns busy/done, the product and the norm shift.
interface mant_mult_seq_if #(
    parameter int MANT_W  = 24,
    parameter int SHIFT_W = 10
);
    logic                  start;
    logic [MANT_W-1:0]     mantA;
    logic [MANT_W-1:0]     mantB;
    logic                  busy;
    logic                  done;
    logic [2*MANT_W-1:0]   mantProduct;
    logic [SHIFT_W-1:0]    shift;

    modport master (
        output start, mantA, mantB,
        input  busy, done, mantProduct, shift
    );

    modport slave (
        input  start, mantA, mantB,
        output busy, done, mantProduct, shift
    );
endinterface

// File: rtl/mant_mult_seq.sv
// Radix-2 shift-add significand multiplier: 24 add steps, then one normalise step.
// Takes 25 clocks from accept to the done pulse. A start seen while busy is dropped, not queued.
module mant_mult_seq #(
    parameter int MANT_W  = 24,
    parameter int SHIFT_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    mant_mult_seq_if.slave  bus
);
    localparam int PROD_W = 2 * MANT_W;
    localparam int IDX_W  = $clog2(PROD_W);
    localparam int CNT_W  = $clog2(MANT_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;

    logic [1:0]          r_state;
    logic [PROD_W-1:0]   r_mcand;
    logic [MANT_W-1:0]   r_mplier;
    logic [PROD_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [PROD_W-1:0]   r_prod;
    logic [SHIFT_W-1:0]  r_shift;

    logic [IDX_W-1:0]    w_lead;
    logic                w_nz;
    logic [SHIFT_W-1:0]  w_shift;

    always_comb begin
        w_lead = '0;
        w_nz   = 1'b0;
        for (int i = 0; i < PROD_W; i++) begin
            if (r_acc[i]) begin
                w_lead = IDX_W'(i);
                w_nz   = 1'b1;
            end
        end
    end

    // A zero product gets the most-negative code so the bit-select stage falls back to a zero mantissa.
    assign w_shift = w_nz ? (SHIFT_W'(w_lead) - SHIFT_W'(PROD_W - 2))
                          : {1'b1, {(SHIFT_W-1){1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_prod   <= '0;
            r_shift  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= bus.start;
                    if (bus.start) begin
                        r_mcand  <= PROD_W'(bus.mantA);
                        r_mplier <= bus.mantB;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_MULT;
                    end
                end
                S_MULT: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(MANT_W - 1)) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_prod  <= r_acc;
                    r_shift <= w_shift;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.mantProduct = r_prod;
    assign bus.shift       = r_shift;
endmodule
